// File: rtl/hazard_scoreboard_unit.sv
// Hazard and forwarding control for the in-order pipeline: operand forwarding, load-use bubbles,
// a per-register scoreboard for variable-latency writers and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_REGS       = 32,
  parameter int LOAD_USE_STALL = 1,
  parameter int PERF_W         = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [REG_ADDR_W-1:0]             SourceReg1Dec,
  input  logic [REG_ADDR_W-1:0]             SourceReg2Dec,
  input  logic [REG_ADDR_W-1:0]             SourceReg1Exec,
  input  logic [REG_ADDR_W-1:0]             SourceReg2Exec,
  input  logic [REG_ADDR_W-1:0]             DestRegExec,
  input  logic [REG_ADDR_W-1:0]             DestRegMem,
  input  logic [REG_ADDR_W-1:0]             DestRegWriteBack,
  input  logic                              RegisterWriteMem,
  input  logic                              RegisterWriteWriteBack,
  input  logic                              LoadExec,
  input  logic                              LongOpIssueExec,
  input  logic                              LongOpDone,
  input  logic [REG_ADDR_W-1:0]             LongOpDestReg,
  input  logic                              ProgramCounterSourceExec,
  output logic [1:0]                        ForwardingReg1Exec,
  output logic [1:0]                        ForwardingReg2Exec,
  output logic                              StallFetch_o,
  output logic                              StallDecode_o,
  output logic                              FlushDecode,
  output logic                              FlushExec,
  output logic [$clog2(NUM_REGS+1)-1:0]     PendingCount,
  output logic [PERF_W-1:0]                 StallCycleCount
);

  localparam int PEND_W = $clog2(NUM_REGS+1);

  logic [1:0]          ld_cnt_q, ld_cnt_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [PERF_W-1:0]   perf_q, perf_d;

  logic load_use_det;
  logic load_stall;
  logic score_stall;
  logic stall;

  always_comb begin
    ForwardingReg1Exec = 2'b00;
    ForwardingReg2Exec = 2'b00;
    if (!reset) begin
      // Mem stage holds the younger result, so it wins over WriteBack.
      if (SourceReg1Exec != '0 && SourceReg1Exec == DestRegMem && RegisterWriteMem)
        ForwardingReg1Exec = 2'b10;
      else if (SourceReg1Exec != '0 && SourceReg1Exec == DestRegWriteBack && RegisterWriteWriteBack)
        ForwardingReg1Exec = 2'b01;
      if (SourceReg2Exec != '0 && SourceReg2Exec == DestRegMem && RegisterWriteMem)
        ForwardingReg2Exec = 2'b10;
      else if (SourceReg2Exec != '0 && SourceReg2Exec == DestRegWriteBack && RegisterWriteWriteBack)
        ForwardingReg2Exec = 2'b01;
    end
  end

  always_comb begin
    load_use_det = LoadExec && (DestRegExec != '0) &&
                   ((DestRegExec == SourceReg1Dec) || (DestRegExec == SourceReg2Dec));
    load_stall   = load_use_det || (ld_cnt_q != 2'd0);
    // Registered bits only: a completing long op releases its reader one cycle later.
    score_stall  = sb_q[SourceReg1Dec] || sb_q[SourceReg2Dec];
    stall        = (load_stall || score_stall) && !ProgramCounterSourceExec && !reset;

    StallFetch_o  = stall;
    StallDecode_o = stall;
    FlushExec     = reset || stall || ProgramCounterSourceExec;
    FlushDecode   = reset || ProgramCounterSourceExec;
  end

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (ProgramCounterSourceExec)
      ld_cnt_d = 2'd0;
    else if (load_use_det)
      ld_cnt_d = 2'(LOAD_USE_STALL - 1);
    else if (ld_cnt_q != 2'd0)
      ld_cnt_d = ld_cnt_q - 2'd1;
  end

  always_comb begin
    sb_d = sb_q;
    if (LongOpDone && LongOpDestReg != '0)
      sb_d[LongOpDestReg] = 1'b0;
    // Applied after the clear so a same-cycle set on the same register wins.
    if (LongOpIssueExec && DestRegExec != '0)
      sb_d[DestRegExec] = 1'b1;

    pend_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      pend_d = pend_d + PEND_W'(sb_d[i]);
  end

  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != {PERF_W{1'b1}}))
      perf_d = perf_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt_q <= 2'd0;
      sb_q     <= '0;
      pend_q   <= '0;
      perf_q   <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      sb_q     <= sb_d;
      pend_q   <= pend_d;
      perf_q   <= perf_d;
    end
  end

  assign PendingCount    = pend_q;
  assign StallCycleCount = perf_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: a 3-bubble / 4-bit-counter instance plus a 1-bubble default-width instance on shared inputs.
module tb_hazard_scoreboard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] SourceReg1Dec, SourceReg2Dec, SourceReg1Exec, SourceReg2Exec;
  logic [4:0] DestRegExec, DestRegMem, DestRegWriteBack, LongOpDestReg;
  logic       RegisterWriteMem, RegisterWriteWriteBack, LoadExec;
  logic       LongOpIssueExec, LongOpDone, ProgramCounterSourceExec;

  logic [1:0] fwd1, fwd2, fwd1_b, fwd2_b;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic       stall_f_b, stall_d_b, flush_d_b, flush_e_b;
  logic [5:0] pend, pend_b;
  logic [3:0] perf;
  logic [31:0] perf_b;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard_unit #(.LOAD_USE_STALL(3), .PERF_W(4)) dut (
    .clk(clk), .reset(reset),
    .SourceReg1Dec(SourceReg1Dec), .SourceReg2Dec(SourceReg2Dec),
    .SourceReg1Exec(SourceReg1Exec), .SourceReg2Exec(SourceReg2Exec),
    .DestRegExec(DestRegExec), .DestRegMem(DestRegMem), .DestRegWriteBack(DestRegWriteBack),
    .RegisterWriteMem(RegisterWriteMem), .RegisterWriteWriteBack(RegisterWriteWriteBack),
    .LoadExec(LoadExec), .LongOpIssueExec(LongOpIssueExec), .LongOpDone(LongOpDone),
    .LongOpDestReg(LongOpDestReg), .ProgramCounterSourceExec(ProgramCounterSourceExec),
    .ForwardingReg1Exec(fwd1), .ForwardingReg2Exec(fwd2),
    .StallFetch_o(stall_f), .StallDecode_o(stall_d),
    .FlushDecode(flush_d), .FlushExec(flush_e),
    .PendingCount(pend), .StallCycleCount(perf)
  );

  hazard_scoreboard_unit dut1 (
    .clk(clk), .reset(reset),
    .SourceReg1Dec(SourceReg1Dec), .SourceReg2Dec(SourceReg2Dec),
    .SourceReg1Exec(SourceReg1Exec), .SourceReg2Exec(SourceReg2Exec),
    .DestRegExec(DestRegExec), .DestRegMem(DestRegMem), .DestRegWriteBack(DestRegWriteBack),
    .RegisterWriteMem(RegisterWriteMem), .RegisterWriteWriteBack(RegisterWriteWriteBack),
    .LoadExec(LoadExec), .LongOpIssueExec(LongOpIssueExec), .LongOpDone(LongOpDone),
    .LongOpDestReg(LongOpDestReg), .ProgramCounterSourceExec(ProgramCounterSourceExec),
    .ForwardingReg1Exec(fwd1_b), .ForwardingReg2Exec(fwd2_b),
    .StallFetch_o(stall_f_b), .StallDecode_o(stall_d_b),
    .FlushDecode(flush_d_b), .FlushExec(flush_e_b),
    .PendingCount(pend_b), .StallCycleCount(perf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    SourceReg1Dec = 0; SourceReg2Dec = 0; SourceReg1Exec = 0; SourceReg2Exec = 0;
    DestRegExec = 0; DestRegMem = 0; DestRegWriteBack = 0; LongOpDestReg = 0;
    RegisterWriteMem = 0; RegisterWriteWriteBack = 0; LoadExec = 0;
    LongOpIssueExec = 0; LongOpDone = 0; ProgramCounterSourceExec = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    SourceReg1Exec = 5; DestRegMem = 5; RegisterWriteMem = 1;
    tick();
    total++; if (fwd1 !== 2'b00) begin bad++; $display("FAIL reset_fwd1 got=%b want=00", fwd1); end
    total++; if (stall_f !== 1'b0 || stall_d !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b%b want=00", stall_f, stall_d); end
    total++; if (flush_d !== 1'b1 || flush_e !== 1'b1) begin bad++; $display("FAIL reset_flush got=%b%b want=11", flush_d, flush_e); end
    total++; if (pend !== 6'd0 || perf !== 4'd0) begin bad++; $display("FAIL reset_counts pend=%0d perf=%0d want=0,0", pend, perf); end
    reset = 1'b0;
    clear_inputs();
    #1;
    total++; if (flush_d !== 1'b0 || flush_e !== 1'b0) begin bad++; $display("FAIL reset_release_flush got=%b%b want=00", flush_d, flush_e); end
  endtask

  task automatic test_forwarding();
    tick();
    DestRegMem = 5; DestRegWriteBack = 5; RegisterWriteMem = 1; RegisterWriteWriteBack = 1;
    SourceReg1Exec = 5;
    #1;
    total++; if (fwd1 !== 2'b10) begin bad++; $display("FAIL fwd_mem_prio got=%b want=10", fwd1); end
    RegisterWriteMem = 0;
    #1;
    total++; if (fwd1 !== 2'b01) begin bad++; $display("FAIL fwd_wb got=%b want=01", fwd1); end
    RegisterWriteMem = 1; DestRegMem = 0; DestRegWriteBack = 0; SourceReg2Exec = 0;
    #1;
    total++; if (fwd2 !== 2'b00) begin bad++; $display("FAIL fwd_r0 got=%b want=00", fwd2); end
    total++; if (fwd1 !== 2'b00) begin bad++; $display("FAIL fwd_nomatch got=%b want=00", fwd1); end
    SourceReg1Exec = 3; SourceReg2Exec = 4; DestRegMem = 3; DestRegWriteBack = 4;
    #1;
    total++; if (fwd1 !== 2'b10 || fwd2 !== 2'b01) begin bad++; $display("FAIL fwd_split got=%b,%b want=10,01", fwd1, fwd2); end
    RegisterWriteWriteBack = 0;
    #1;
    total++; if (fwd2 !== 2'b00) begin bad++; $display("FAIL fwd_wb_disabled got=%b want=00", fwd2); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    tick();
    LoadExec = 1; DestRegExec = 7; SourceReg2Dec = 7;
    #1;
    total++; if (stall_f !== 1'b1 || flush_e !== 1'b1 || flush_d !== 1'b0) begin bad++; $display("FAIL ld_cycle1 stall=%b flushE=%b flushD=%b want=1,1,0", stall_f, flush_e, flush_d); end
    total++; if (stall_f_b !== 1'b1) begin bad++; $display("FAIL ld1_cycle1 got=%b want=1", stall_f_b); end
    tick();
    LoadExec = 0; DestRegExec = 0;
    #1;
    total++; if (stall_f !== 1'b1 || stall_d !== 1'b1 || flush_e !== 1'b1) begin bad++; $display("FAIL ld_cycle2 got=%b%b%b want=111", stall_f, stall_d, flush_e); end
    total++; if (stall_f_b !== 1'b0) begin bad++; $display("FAIL ld1_cycle2 got=%b want=0", stall_f_b); end
    tick();
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL ld_cycle3 got=%b want=1", stall_f); end
    tick();
    total++; if (stall_f !== 1'b0 || flush_e !== 1'b0) begin bad++; $display("FAIL ld_cycle4 got=%b%b want=00", stall_f, flush_e); end
    total++; if (perf !== 4'd3) begin bad++; $display("FAIL ld_perf got=%0d want=3", perf); end
    total++; if (perf_b !== 32'd1) begin bad++; $display("FAIL ld1_perf got=%0d want=1", perf_b); end
    clear_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    tick();
    LongOpIssueExec = 1; DestRegExec = 9;
    #1;
    total++; if (pend !== 6'd0) begin bad++; $display("FAIL sb_pend_before got=%0d want=0", pend); end
    tick();
    LongOpIssueExec = 0; DestRegExec = 0; SourceReg1Dec = 9;
    #1;
    total++; if (pend !== 6'd1) begin bad++; $display("FAIL sb_pend_set got=%0d want=1", pend); end
    total++; if (stall_f !== 1'b1 || flush_e !== 1'b1) begin bad++; $display("FAIL sb_stall got=%b%b want=11", stall_f, flush_e); end
    tick();
    LongOpDone = 1; LongOpDestReg = 9;
    #1;
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL sb_no_bypass got=%b want=1", stall_f); end
    tick();
    LongOpDone = 0; LongOpDestReg = 0;
    #1;
    total++; if (stall_f !== 1'b0 || pend !== 6'd0) begin bad++; $display("FAIL sb_release stall=%b pend=%0d want=0,0", stall_f, pend); end
    SourceReg1Dec = 0;
    tick();
    LongOpIssueExec = 1; DestRegExec = 9;
    tick();
    LongOpDone = 1; LongOpDestReg = 9;
    tick();
    LongOpIssueExec = 0; DestRegExec = 0; LongOpDone = 0; LongOpDestReg = 0; SourceReg2Dec = 9;
    #1;
    total++; if (pend !== 6'd1 || stall_f !== 1'b1) begin bad++; $display("FAIL sb_set_wins pend=%0d stall=%b want=1,1", pend, stall_f); end
    LongOpIssueExec = 1; DestRegExec = 0;
    tick();
    LongOpIssueExec = 0;
    #1;
    total++; if (pend !== 6'd1) begin bad++; $display("FAIL sb_r0_never_set got=%0d want=1", pend); end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    LongOpIssueExec = 1; DestRegExec = 12;
    tick();
    LongOpIssueExec = 0; LoadExec = 1; DestRegExec = 7; SourceReg1Dec = 7;
    #1;
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL br_detect got=%b want=1", stall_f); end
    tick();
    LoadExec = 0; DestRegExec = 0;
    #1;
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL br_ldcnt2 got=%b want=1", stall_f); end
    ProgramCounterSourceExec = 1;
    #1;
    total++; if (stall_f !== 1'b0 || flush_d !== 1'b1 || flush_e !== 1'b1) begin bad++; $display("FAIL br_override stall=%b flushD=%b flushE=%b want=0,1,1", stall_f, flush_d, flush_e); end
    tick();
    ProgramCounterSourceExec = 0;
    #1;
    total++; if (stall_f !== 1'b0 || flush_e !== 1'b0) begin bad++; $display("FAIL br_ldcnt_cleared got=%b%b want=00", stall_f, flush_e); end
    total++; if (pend !== 6'd1) begin bad++; $display("FAIL br_sb_kept got=%0d want=1", pend); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); LongOpIssueExec = 1; DestRegExec = 3;
    tick(); DestRegExec = 4;
    tick(); DestRegExec = 5;
    tick(); LongOpIssueExec = 0; LoadExec = 1; DestRegExec = 6; SourceReg2Dec = 6;
    #1;
    total++; if (pend !== 6'd3) begin bad++; $display("FAIL rm_pend3 got=%0d want=3", pend); end
    tick(); LoadExec = 0; DestRegExec = 0;
    tick();
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL rm_ldcnt1 got=%b want=1", stall_f); end
    #2 reset = 1'b1;
    #1;
    total++; if (pend !== 6'd0 || stall_f !== 1'b0 || stall_d !== 1'b0) begin bad++; $display("FAIL rm_async pend=%0d stall=%b%b want=0,00", pend, stall_f, stall_d); end
    total++; if (flush_d !== 1'b1 || flush_e !== 1'b1) begin bad++; $display("FAIL rm_flush got=%b%b want=11", flush_d, flush_e); end
    tick();
    reset = 1'b0; SourceReg1Dec = 3; SourceReg2Dec = 4;
    #1;
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL rm_after_release got=%b want=0", stall_f); end
    tick();
    total++; if (stall_f !== 1'b0 || pend !== 6'd0) begin bad++; $display("FAIL rm_quiet stall=%b pend=%0d want=0,0", stall_f, pend); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    LongOpIssueExec = 1; DestRegExec = 9;
    tick();
    LongOpIssueExec = 0; DestRegExec = 0; SourceReg1Dec = 9;
    repeat (20) tick();
    total++; if (perf !== 4'd15) begin bad++; $display("FAIL sat_perf4 got=%0d want=15", perf); end
    total++; if (perf_b !== 32'd20) begin bad++; $display("FAIL sat_perf32 got=%0d want=20", perf_b); end
    SourceReg1Dec = 0;
    tick();
    total++; if (perf !== 4'd15 || stall_f !== 1'b0) begin bad++; $display("FAIL sat_hold perf=%0d stall=%b want=15,0", perf, stall_f); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_scoreboard();
    test_branch();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor of the in-order pipeline's hazard/forwarding unit. It adds a per-register scoreboard for variable-latency writers (mul/div, slow memory), a programmable multi-cycle load-use stall counter and a saturating stall-cycle performance counter. It sits beside the Decode/Exec/Mem/WriteBack pipeline registers and drives forwarding muxes, stall enables and flush controls.

Parameters:
REG_ADDR_W, 5, register address width
NUM_REGS, 32, architectural registers (2**REG_ADDR_W); register 0 hardwired zero
LOAD_USE_STALL, 1, bubble cycles inserted for a load-use dependency (legal 1..3)
PERF_W, 32, stall performance counter width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous active-high reset
SourceReg1Dec  in  REG_ADDR_W  Decode source 1
SourceReg2Dec  in  REG_ADDR_W  Decode source 2
SourceReg1Exec  in  REG_ADDR_W  Exec source 1
SourceReg2Exec  in  REG_ADDR_W  Exec source 2
DestRegExec  in  REG_ADDR_W  Exec destination
DestRegMem  in  REG_ADDR_W  Mem destination
DestRegWriteBack  in  REG_ADDR_W  WriteBack destination
RegisterWriteMem  in  1  Mem instruction writes a register
RegisterWriteWriteBack  in  1  WriteBack instruction writes a register
LoadExec  in  1  Exec instruction is a load
LongOpIssueExec  in  1  Exec instruction is a variable-latency op leaving Exec this cycle
LongOpDone  in  1  variable-latency unit writing back this cycle
LongOpDestReg  in  REG_ADDR_W  destination of completing long op
ProgramCounterSourceExec  in  1  branch/jump taken in Exec
ForwardingReg1Exec  out  2  00 regfile, 10 Mem ALU result, 01 WriteBack result
ForwardingReg2Exec  out  2  same encoding
StallFetch_o  out  1  hold PC
StallDecode_o  out  1  hold Fetch/Decode register
FlushDecode  out  1  clear Fetch/Decode register
FlushExec  out  1  insert bubble into Decode/Exec register
PendingCount  out  clog2(NUM_REGS+1)  scoreboard bits set
StallCycleCount  out  PERF_W  saturating count of stalled cycles

Behaviour:
- Reset (async, any cycle incl. mid-stall): scoreboard all 0, load counter 0, StallCycleCount 0. While reset is high: Forwarding* = 00, stalls 0, FlushDecode = FlushExec = 1.
- Forwarding (combinational): per Exec source, 10 if source != 0 && source == DestRegMem && RegisterWriteMem; else 01 if source != 0 && == DestRegWriteBack && RegisterWriteWriteBack; else 00. Mem has priority.
- Load-use detect: LoadExec && DestRegExec != 0 && DestRegExec matches either Decode source.
- Load counter (LdCnt, 2 bits): on detect (no branch), LdCnt <= LOAD_USE_STALL-1; while LdCnt != 0 it decrements each cycle. LoadStall = detect || LdCnt != 0. LOAD_USE_STALL=1 gives exactly one stall cycle, identical to the previous generation.
- Scoreboard: on LongOpIssueExec with DestRegExec != 0, set bit[DestRegExec] next edge. On LongOpDone with LongOpDestReg != 0, clear bit. If the same register is set and cleared in one cycle, set wins. Register 0 is never set.
- ScoreStall = bit[SourceReg1Dec] || bit[SourceReg2Dec], read from the registered bits. No bypass from the same-cycle LongOpDone; the instruction proceeds the cycle after the clear.
- Stall = (LoadStall || ScoreStall) && !ProgramCounterSourceExec. StallFetch_o = StallDecode_o = Stall. FlushExec = Stall || ProgramCounterSourceExec. FlushDecode = ProgramCounterSourceExec.
- Branch priority: a taken branch suppresses the stall and clears LdCnt to 0 next edge. Scoreboard bits persist; older long ops still complete.
- PendingCount = popcount of the scoreboard, registered (updates with the bits).
- StallCycleCount increments on each Stall cycle and saturates at all-ones.

Test Plan:
- Forwarding: DestRegMem=DestRegWriteBack=5, both write enables 1, SourceReg1Exec=5 -> ForwardingReg1Exec=10. Drop RegisterWriteMem -> 01. SourceReg2Exec=0 with Dest=0 -> 00.
- Load-use, LOAD_USE_STALL=3: LoadExec, DestRegExec=7, SourceReg2Dec=7 for one cycle, then bubble -> Stall and FlushExec high exactly 3 cycles. StallCycleCount=3.
- Scoreboard: LongOpIssueExec dest 9 -> PendingCount=1. Decode reads r9 -> stall until LongOpDone dest 9, released the cycle after. Simultaneous set/clear of r9 -> bit stays 1.
- Branch during stall: LdCnt=2 and ProgramCounterSourceExec=1 -> Stall=0, FlushDecode=FlushExec=1, LdCnt=0 next cycle. Scoreboard unchanged.
- Reset mid-operation: assert reset with 3 pending bits and LdCnt=1 -> immediately PendingCount=0, stalls 0, flushes 1. After release, no stall without a new hazard.
- Saturation, PERF_W=4: hold ScoreStall 20 cycles -> StallCycleCount stops at 15.
